// File: rtl/w0rm_peripheral_bus_arbiter.sv
// Two-master round-robin arbiter for the W0RM peripheral bus: captures request
// pulses into one-entry slots, issues one bus transaction at a time, routes responses.
module w0rm_peripheral_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset_n,
  input  logic                  m0_valid_i,
  input  logic                  m0_read_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic                  m1_valid_i,
  input  logic                  m1_read_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m0_valid_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_busy_o,
  output logic                  m1_valid_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_busy_o,
  output logic                  bus_valid_o,
  output logic                  bus_read_o,
  output logic                  bus_write_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  input  logic                  bus_valid_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  timeout_o,
  output logic                  overflow_o
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  owner;
  logic                  last_grant;
  logic [1:0]            pend;
  logic [1:0]            busy;
  logic [1:0]            slot_rd;
  logic [1:0]            slot_wr;
  logic [ADDR_WIDTH-1:0] slot_addr [2];
  logic [DATA_WIDTH-1:0] slot_data [2];
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data  [2];

  logic [1:0]            req_valid;
  logic [1:0]            req_rd;
  logic [1:0]            req_wr;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_data  [2];
  logic                  win;

  always_comb begin
    req_valid   = {m1_valid_i, m0_valid_i};
    req_rd      = {m1_read_i, m0_read_i};
    req_wr      = {m1_write_i, m0_write_i};
    req_addr[0] = m0_addr_i;
    req_addr[1] = m1_addr_i;
    req_data[0] = m0_data_i;
    req_data[1] = m1_data_i;
    // On a tie the master not granted last wins; otherwise the lone pending slot.
    win = (pend[0] && pend[1]) ? ~last_grant : pend[1];
  end

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      pend        <= '0;
      busy        <= '0;
      slot_rd     <= '0;
      slot_wr     <= '0;
      rsp_valid   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
        rsp_data[i]  <= '0;
      end
      bus_valid_o <= 1'b0;
      bus_read_o  <= 1'b0;
      bus_write_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      timeout_o   <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      rsp_valid   <= '0;
      timeout_o   <= 1'b0;
      bus_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|pend) begin
            bus_valid_o <= 1'b1;
            bus_read_o  <= slot_rd[win];
            bus_write_o <= slot_wr[win];
            bus_addr_o  <= slot_addr[win];
            bus_data_o  <= slot_data[win];
            pend[win]   <= 1'b0;
            owner       <= win;
            last_grant  <= win;
            cnt         <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real response takes priority over the timeout on the same edge.
          if (bus_valid_i) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data[owner]  <= bus_data_i;
            busy[owner]      <= 1'b0;
            cnt              <= '0;
            state            <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data[owner]  <= '0;
            busy[owner]      <= 1'b0;
            timeout_o        <= 1'b1;
            cnt              <= '0;
            state            <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      for (int unsigned i = 0; i < 2; i++) begin
        if (req_valid[i]) begin
          if (busy[i]) begin
            overflow_o <= 1'b1;
          end else begin
            pend[i]      <= 1'b1;
            busy[i]      <= 1'b1;
            slot_rd[i]   <= req_rd[i];
            slot_wr[i]   <= req_wr[i];
            slot_addr[i] <= req_addr[i];
            slot_data[i] <= req_data[i];
          end
        end
      end
    end
  end

  assign m0_valid_o = rsp_valid[0];
  assign m1_valid_o = rsp_valid[1];
  assign m0_data_o  = rsp_data[0];
  assign m1_data_o  = rsp_data[1];
  assign m0_busy_o  = busy[0];
  assign m1_busy_o  = busy[1];

endmodule
